// File: rtl/fpu_pkg.sv
// Shared FPU encodings: funct7 opcodes, sequencer state type and default latencies.
package fpu_pkg;

   localparam logic [6:0] F7_FADD     = 7'h00;
   localparam logic [6:0] F7_FSUB     = 7'h04;
   localparam logic [6:0] F7_FMUL     = 7'h08;
   localparam logic [6:0] F7_FSGNJ    = 7'h10;
   localparam logic [6:0] F7_FCMP     = 7'h50;
   localparam logic [6:0] F7_FCVT_S_W = 7'h68;
   localparam logic [6:0] F7_FMV_W_S  = 7'h70;
   localparam logic [6:0] F7_FMV_S_W  = 7'h78;

   localparam int LAT_ADD_DEF = 2;
   localparam int LAT_CVT_DEF = 1;
   localparam int LAT_MAX_DEF = 3;

   localparam int N_LEGAL_F7 = 8;
   localparam logic [6:0] F7_LEGAL [N_LEGAL_F7] = '{
      F7_FADD, F7_FSUB, F7_FMUL, F7_FSGNJ,
      F7_FCMP, F7_FCVT_S_W, F7_FMV_W_S, F7_FMV_S_W
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } fpu_state_e;

endpackage

// File: rtl/fpu_seq_lat.sv
// Combinational funct7 -> pipeline latency decode, shareable with the hazard unit.
// FPU_SEQ_ILLEGAL_EN adds the funct3 input and the illegal-op flag.
module fpu_seq_lat
   import fpu_pkg::*;
#(
   parameter int LAT_ADD = LAT_ADD_DEF,
   parameter int LAT_CVT = LAT_CVT_DEF,
   parameter int CW      = 2
) (
`ifdef FPU_SEQ_ILLEGAL_EN
   input  logic [2:0]    funct3,
   output logic          illegal,
`endif
   input  logic [6:0]    funct7,
   output logic [CW-1:0] lat
);

   always_comb begin
      lat = '0;
      case (funct7)
         F7_FADD, F7_FSUB: lat = CW'(LAT_ADD);
         F7_FCVT_S_W:      lat = CW'(LAT_CVT);
         default:          lat = '0;
      endcase
   end

`ifdef FPU_SEQ_ILLEGAL_EN
   logic [N_LEGAL_F7-1:0] legal_hit;

   generate
      for (genvar gi = 0; gi < N_LEGAL_F7; gi++) begin : g_legal
         assign legal_hit[gi] = (funct7 == F7_LEGAL[gi]);
      end
   endgenerate

   // sign-inject and compare only define funct3 values 0..2
   assign illegal = ~|legal_hit ||
                    (((funct7 == F7_FSGNJ) || (funct7 == F7_FCMP)) && (funct3 > 3'd2));
`endif

endmodule

// File: rtl/fpu_seq.sv
// Issue/sequencing stage in front of the FPU: holds operands for the op latency,
// captures the result and returns it with its rd tag. FPU_SEQ_ILLEGAL_EN adds resp_illegal.
module fpu_seq
   import fpu_pkg::*;
#(
   parameter int LAT_ADD = LAT_ADD_DEF,
   parameter int LAT_CVT = LAT_CVT_DEF,
   parameter int LAT_MAX = LAT_MAX_DEF
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_funct3,
   input  logic [6:0]  req_funct7,
   input  logic [31:0] req_x1,
   input  logic [31:0] req_x2,
   input  logic [4:0]  req_rd,
   output logic [2:0]  fpu_funct3,
   output logic [6:0]  fpu_funct7,
   output logic [31:0] fpu_x1,
   output logic [31:0] fpu_x2,
   input  logic [31:0] fpu_y,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic [4:0]  resp_rd
`ifdef FPU_SEQ_ILLEGAL_EN
   ,
   output logic        resp_illegal
`endif
);

   localparam int CW = $clog2(LAT_MAX + 1);

   fpu_state_e    state_reg, state_next;
   logic [CW-1:0] count_reg, op_lat;
   logic [2:0]    funct3_reg;
   logic [6:0]    funct7_reg;
   logic [31:0]   x1_reg, x2_reg, resp_data_reg, result;
   logic [4:0]    rd_reg, resp_rd_reg;
   logic          accept, handshake;

   assign accept    = req_valid && req_ready;
   assign handshake = resp_valid && resp_ready;

`ifdef FPU_SEQ_ILLEGAL_EN
   logic op_illegal, illegal_reg, resp_illegal_reg;

   fpu_seq_lat #(.LAT_ADD(LAT_ADD), .LAT_CVT(LAT_CVT), .CW(CW)) u_lat (
      .funct3  (req_funct3),
      .illegal (op_illegal),
      .funct7  (req_funct7),
      .lat     (op_lat)
   );

   assign result       = illegal_reg ? 32'h0 : fpu_y;
   assign resp_illegal = resp_illegal_reg;
`else
   fpu_seq_lat #(.LAT_ADD(LAT_ADD), .LAT_CVT(LAT_CVT), .CW(CW)) u_lat (
      .funct7 (req_funct7),
      .lat    (op_lat)
   );

   assign result = fpu_y;
`endif

   always_ff @(posedge clk) begin
      if (rstn) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = BUSY;
         BUSY:    if (count_reg == '0) state_next = DONE;
         DONE:    if (handshake) state_next = accept ? BUSY : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state_reg == IDLE) || ((state_reg == DONE) && resp_ready);
      resp_valid = (state_reg == DONE);
   end

   // accept is only possible in IDLE/DONE, so it never collides with the BUSY countdown
   always_ff @(posedge clk) begin
      if (rstn) begin
         count_reg     <= '0;
         funct3_reg    <= '0;
         funct7_reg    <= '0;
         x1_reg        <= '0;
         x2_reg        <= '0;
         rd_reg        <= '0;
         resp_data_reg <= '0;
         resp_rd_reg   <= '0;
      end else if (accept) begin
         count_reg  <= op_lat;
         funct3_reg <= req_funct3;
         funct7_reg <= req_funct7;
         x1_reg     <= req_x1;
         x2_reg     <= req_x2;
         rd_reg     <= req_rd;
      end else if (state_reg == BUSY) begin
         if (count_reg != '0) begin
            count_reg <= count_reg - CW'(1);
         end else begin
            resp_data_reg <= result;
            resp_rd_reg   <= rd_reg;
         end
      end
   end

`ifdef FPU_SEQ_ILLEGAL_EN
   always_ff @(posedge clk) begin
      if (rstn) begin
         illegal_reg      <= 1'b0;
         resp_illegal_reg <= 1'b0;
      end else if (accept) begin
         illegal_reg <= op_illegal;
      end else if ((state_reg == BUSY) && (count_reg == '0)) begin
         resp_illegal_reg <= illegal_reg;
      end
   end
`endif

   assign fpu_funct3 = funct3_reg;
   assign fpu_funct7 = funct7_reg;
   assign fpu_x1     = x1_reg;
   assign fpu_x2     = x2_reg;
   assign resp_data  = resp_data_reg;
   assign resp_rd    = resp_rd_reg;

endmodule
